// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner. A prescaler paces the digit scan,
// and loaded data is double-buffered so the display only changes at a frame boundary.
`timescale 1ns/1ps
module display_scan_controller #(
    parameter int unsigned CLK_DIV = 1000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    input  logic        lzb_en_i,
    output logic [2:0]  state_o,
    output logic [3:0]  current_digit_o,
    output logic [3:0]  anode_o,
    output logic        dp_o,
    output logic        blank_o,
    output logic        tick_o,
    output logic        frame_o
);

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned VALUE_W = 16;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned NIB_W   = 4;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [DIGITS-1:0]  dp;
    } frame_data_t;

    typedef enum logic [1:0] {
        DIGIT0 = 2'd0,
        DIGIT1 = 2'd1,
        DIGIT2 = 2'd2,
        DIGIT3 = 2'd3
    } digit_e;

    digit_e             state_q;
    digit_e             state_d;
    logic [PRESC_W-1:0] presc_q;
    frame_data_t        disp_q;
    frame_data_t        pend_q;
    frame_data_t        load_data;
    logic               pend_valid_q;
    logic               frame_q;
    logic               tick;
    logic               boundary;
    logic               blank;
    logic [NIB_W-1:0]   nibble;

    assign tick      = (presc_q == PRESC_MAX);
    assign boundary  = tick && (state_q == DIGIT3);
    assign load_data = '{value: value_i, dp: dp_i};

    // Prescaler: counts 0..CLK_DIV-1, wrapping on the tick.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // Scan state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= DIGIT0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance one digit per tick, wrapping 3 -> 0.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                DIGIT0:  state_d = DIGIT1;
                DIGIT1:  state_d = DIGIT2;
                DIGIT2:  state_d = DIGIT3;
                default: state_d = DIGIT0;
            endcase
        end
    end

    // Double buffer: loads land in pending unless they coincide with the boundary,
    // in which case they go straight to the display and supersede pending.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            frame_q <= boundary && (load_i || pend_valid_q);
            if (boundary && load_i) begin
                disp_q       <= load_data;
                pend_valid_q <= 1'b0;
            end else if (load_i) begin
                pend_q       <= load_data;
                pend_valid_q <= 1'b1;
            end else if (boundary && pend_valid_q) begin
                disp_q       <= pend_q;
                pend_valid_q <= 1'b0;
            end
        end
    end

    // Active-digit nibble and leading-zero blanking (digit 0 is always shown).
    always_comb begin
        nibble = disp_q.value[3:0];
        blank  = 1'b0;
        unique case (state_q)
            DIGIT0: begin
                nibble = disp_q.value[3:0];
                blank  = 1'b0;
            end
            DIGIT1: begin
                nibble = disp_q.value[7:4];
                blank  = lzb_en_i && (disp_q.value[15:4] == 12'h000);
            end
            DIGIT2: begin
                nibble = disp_q.value[11:8];
                blank  = lzb_en_i && (disp_q.value[15:8] == 8'h00);
            end
            default: begin
                nibble = disp_q.value[15:12];
                blank  = lzb_en_i && (disp_q.value[15:12] == 4'h0);
            end
        endcase
    end

    assign state_o         = {1'b0, state_q};
    assign current_digit_o = nibble;
    assign blank_o         = blank;
    assign anode_o         = blank ? 4'b1111 : ~(4'b0001 << state_q);
    assign dp_o            = blank ? 1'b1 : ~disp_q.dp[state_q];
    assign tick_o          = tick;
    assign frame_o         = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with CLK_DIV = 4 (16-cycle frames).
`timescale 1ns/1ps
module tb_display_scan_controller;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic        lzb_en_i;
    logic [2:0]  state_o;
    logic [3:0]  current_digit_o;
    logic [3:0]  anode_o;
    logic        dp_o;
    logic        blank_o;
    logic        tick_o;
    logic        frame_o;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] dig;
        logic [3:0] an;
        logic       dp;
        logic       blank;
        logic       tick;
        logic       frame;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    exp_t want;
    int   cyc;
    int   passed;
    int   total;

    display_scan_controller #(.CLK_DIV(4)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .value_i         (value_i),
        .dp_i            (dp_i),
        .load_i          (load_i),
        .lzb_en_i        (lzb_en_i),
        .state_o         (state_o),
        .current_digit_o (current_digit_o),
        .anode_o         (anode_o),
        .dp_o            (dp_o),
        .blank_o         (blank_o),
        .tick_o          (tick_o),
        .frame_o         (frame_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected outputs for one cycle at frame phase ph (0..15) showing v/d.
    function automatic exp_t mk(input logic [15:0] v, input logic [3:0] d,
                                input logic lz, input int ph, input logic fr);
        exp_t        e;
        int          st;
        logic [15:0] upper;
        st      = ph / 4;
        upper   = v >> (4 * st);
        e.st    = 3'(st);
        e.dig   = upper[3:0];
        e.blank = lz && (st != 0) && (upper == 16'h0000);
        case (st)
            0:       e.an = 4'b1110;
            1:       e.an = 4'b1101;
            2:       e.an = 4'b1011;
            default: e.an = 4'b0111;
        endcase
        if (e.blank) e.an = 4'b1111;
        e.dp    = e.blank ? 1'b1 : ~d[st];
        e.tick  = ((ph % 4) == 3);
        e.frame = fr && (ph == 0);
        return e;
    endfunction

    function automatic void push_frame(input logic [15:0] v, input logic [3:0] d,
                                       input logic lz, input logic fr, input int from_ph);
        for (int ph = from_ph; ph < 16; ph++) sb.push_back(mk(v, d, lz, ph, fr));
    endfunction

    function automatic exp_t sample();
        exp_t e;
        e.st    = state_o;
        e.dig   = current_digit_o;
        e.an    = anode_o;
        e.dp    = dp_o;
        e.blank = blank_o;
        e.tick  = tick_o;
        e.frame = frame_o;
        return e;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle_to(input int phase);
        for (int i = 0; i < 16 && (cyc % 16) != phase; i++) step();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; value_i = '0; dp_i = '0; load_i = 1'b0; lzb_en_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++; if (state_o !== 3'd0)         $display("FAIL reset_state got=%0d want=0", state_o); else passed++;
        total++; if (current_digit_o !== 4'h0) $display("FAIL reset_digit got=%h want=0", current_digit_o); else passed++;
        total++; if (anode_o !== 4'b1110)      $display("FAIL reset_anode got=%b want=1110", anode_o); else passed++;
        total++; if (dp_o !== 1'b1)            $display("FAIL reset_dp got=%b want=1", dp_o); else passed++;
        total++; if (blank_o !== 1'b0)         $display("FAIL reset_blank got=%b want=0", blank_o); else passed++;
        total++; if (tick_o !== 1'b0)          $display("FAIL reset_tick got=%b want=0", tick_o); else passed++;
        total++; if (frame_o !== 1'b0)         $display("FAIL reset_frame got=%b want=0", frame_o); else passed++;
        reset_i = 1'b0;
        cyc = 0;
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 0);
        while (sb.size() > 0) begin
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) $display("FAIL post_reset_scan cyc=%0d got=%h want=%h", cyc, got, want); else passed++;
            step();
        end
    endtask

    task automatic test_scan_order();
        idle_to(4);
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 4);
        push_frame(16'h1A3F, 4'h0, 1'b0, 1'b1, 0);
        push_frame(16'h1A3F, 4'h0, 1'b0, 1'b0, 0);
        value_i = 16'h1A3F; dp_i = 4'h0; lzb_en_i = 1'b0;
        for (int i = 0; sb.size() > 0; i++) begin
            load_i = (i == 0);
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) $display("FAIL scan_order cyc=%0d got=%h want=%h", cyc, got, want); else passed++;
            step();
        end
        load_i = 1'b0;
    endtask

    task automatic test_blanking();
        idle_to(0);
        lzb_en_i = 1'b1; dp_i = 4'h0;
        push_frame(16'h1A3F, 4'h0, 1'b1, 1'b0, 0);
        push_frame(16'h0005, 4'h0, 1'b1, 1'b1, 0);
        push_frame(16'h0000, 4'h0, 1'b1, 1'b1, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            load_i = 1'b0;
            if (i == 0)  begin value_i = 16'h0005; load_i = 1'b1; end
            if (i == 16) begin value_i = 16'h0000; load_i = 1'b1; end
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) $display("FAIL blanking cyc=%0d got=%h want=%h", cyc, got, want); else passed++;
            step();
        end
        load_i = 1'b0;
    endtask

    task automatic test_buffering();
        lzb_en_i = 1'b0;
        idle_to(4);
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 4);
        push_frame(16'h2222, 4'h0, 1'b0, 1'b1, 0);
        push_frame(16'h2222, 4'h0, 1'b0, 1'b0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            load_i = 1'b0;
            if (i == 0) begin value_i = 16'h1111; load_i = 1'b1; end
            if (i == 4) begin value_i = 16'h2222; load_i = 1'b1; end
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) $display("FAIL buffering cyc=%0d got=%h want=%h", cyc, got, want); else passed++;
            step();
        end
        load_i = 1'b0;
    endtask

    task automatic test_coincident_load();
        idle_to(4);
        push_frame(16'h2222, 4'h0, 1'b0, 1'b0, 4);
        push_frame(16'h00C0, 4'h0, 1'b0, 1'b1, 0);
        push_frame(16'h00C0, 4'h0, 1'b0, 1'b0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            load_i = 1'b0;
            if (i == 0)  begin value_i = 16'h3333; load_i = 1'b1; end
            if (i == 11) begin value_i = 16'h00C0; load_i = 1'b1; end
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) $display("FAIL coincident_load cyc=%0d got=%h want=%h", cyc, got, want); else passed++;
            step();
        end
        load_i = 1'b0;
    endtask

    task automatic test_decimal_point();
        idle_to(15);
        push_frame(16'h00C0, 4'h0, 1'b0, 1'b0, 15);
        push_frame(16'h1234, 4'b0100, 1'b0, 1'b1, 0);
        push_frame(16'h1234, 4'b0100, 1'b0, 1'b0, 0);
        value_i = 16'h1234; dp_i = 4'b0100;
        for (int i = 0; sb.size() > 0; i++) begin
            load_i = (i == 0);
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) $display("FAIL decimal_point cyc=%0d got=%h want=%h", cyc, got, want); else passed++;
            step();
        end
        load_i = 1'b0;
        dp_i = 4'h0;
    endtask

    task automatic test_reset_mid_scan();
        idle_to(4);
        value_i = 16'h5555; dp_i = 4'hF; load_i = 1'b1;
        step();
        load_i = 1'b0;
        idle_to(10);
        reset_i = 1'b1;
        #1;
        total++; if (state_o !== 3'd0)         $display("FAIL midreset_state got=%0d want=0", state_o); else passed++;
        total++; if (anode_o !== 4'b1110)      $display("FAIL midreset_anode got=%b want=1110", anode_o); else passed++;
        total++; if (dp_o !== 1'b1)            $display("FAIL midreset_dp got=%b want=1", dp_o); else passed++;
        total++; if (current_digit_o !== 4'h0) $display("FAIL midreset_digit got=%h want=0", current_digit_o); else passed++;
        total++; if (tick_o !== 1'b0)          $display("FAIL midreset_tick got=%b want=0", tick_o); else passed++;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        cyc = 0;
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 0);
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 0);
        while (sb.size() > 0) begin
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) $display("FAIL reset_mid_scan cyc=%0d got=%h want=%h", cyc, got, want); else passed++;
            step();
        end
    endtask

    initial begin
        cyc = 0; passed = 0; total = 0;
        test_reset();
        test_scan_order();
        test_blanking();
        test_buffering();
        test_coincident_load();
        test_decimal_point();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
